// File: rtl/char_string_render.sv
// Pipelined 5x7 text renderer: draws N_CHARS glyphs from a frame-shadowed string at a programmable origin.
// Optional macro BLINK_EN adds frame-counted blinking gated by blink_req.
module char_string_render #(
  parameter int N_CHARS      = 4,
  parameter int SCALE_LOG2   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_valid,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   frame_tick,
  input  logic [9:0]             start_x,
  input  logic [9:0]             start_y,
  input  logic [6*N_CHARS-1:0]   char_codes,
  input  logic                   blink_req,
  output logic                   display
);

  localparam int CIDX_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [10:0] BOX_W = 11'(N_CHARS * 6 * (1 << SCALE_LOG2));
  localparam logic [10:0] BOX_H = 11'(7 * (1 << SCALE_LOG2));

  // Glyph rows packed top row first, bit 4 of each row is the leftmost column.
  function automatic logic [34:0] font_glyph(input logic [5:0] code);
    case (code)
      6'd0:  font_glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      6'd1:  font_glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      6'd2:  font_glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      6'd3:  font_glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      6'd4:  font_glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      6'd5:  font_glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      6'd6:  font_glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      6'd7:  font_glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      6'd8:  font_glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      6'd9:  font_glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      6'd10: font_glyph = 35'b01110_10001_10001_10001_11111_10001_10001;
      6'd11: font_glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      6'd12: font_glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      6'd13: font_glyph = 35'b11100_10010_10001_10001_10001_10010_11100;
      6'd14: font_glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      6'd15: font_glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      6'd16: font_glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      6'd17: font_glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      6'd18: font_glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      6'd19: font_glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      6'd20: font_glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      6'd21: font_glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      6'd22: font_glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      6'd23: font_glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      6'd24: font_glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      6'd25: font_glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      6'd26: font_glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      6'd27: font_glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd28: font_glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd29: font_glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd30: font_glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      6'd31: font_glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      6'd32: font_glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      6'd33: font_glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      6'd34: font_glyph = 35'b10001_10001_10001_01010_00100_00100_00100;
      6'd35: font_glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      default: font_glyph = '0;
    endcase
  endfunction

  logic [6*N_CHARS-1:0] shadow_reg;
  logic [5:0]           slot_code [N_CHARS];

  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_slot
    assign slot_code[gi] = shadow_reg[6*gi +: 6];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '1;
    end else if (frame_tick) begin
      shadow_reg <= char_codes;
    end
  end

  // Stage 1: box test and cell decode; the slot code is captured here so a
  // pixel coinciding with frame_tick still sees the old string.
  logic [10:0]       dx, dy;
  logic [9:0]        cell_col, cell_row, char_base, col_full;
  logic [CIDX_W-1:0] char_idx;
  logic              in_box_next;

  always_comb begin
    dx          = {1'b0, x} - {1'b0, start_x};
    dy          = {1'b0, y} - {1'b0, start_y};
    in_box_next = pix_valid & ~dx[10] & ~dy[10] & (dx < BOX_W) & (dy < BOX_H);
    cell_col    = dx[9:0] >> SCALE_LOG2;
    cell_row    = dy[9:0] >> SCALE_LOG2;
    char_idx    = '0;
    char_base   = '0;
    for (int i = 1; i < N_CHARS; i++) begin
      if (cell_col >= 10'(6 * i)) begin
        char_idx  = CIDX_W'(i);
        char_base = 10'(6 * i);
      end
    end
    col_full = cell_col - char_base;
  end

  logic       in_box_reg;
  logic [5:0] code_reg;
  logic [2:0] row_reg, col_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_reg <= 1'b0;
      code_reg   <= 6'd63;
      row_reg    <= '0;
      col_reg    <= '0;
    end else begin
      in_box_reg <= in_box_next;
      code_reg   <= slot_code[char_idx];
      row_reg    <= cell_row[2:0];
      col_reg    <= col_full[2:0];
    end
  end

  // Stage 2: font lookup and registered output.
  logic [34:0] glyph;
  logic [4:0]  row_bits;
  logic        pix_bit, blank_gate, display_next;

  always_comb begin
    glyph = font_glyph(code_reg);
    case (row_reg)
      3'd0:    row_bits = glyph[34:30];
      3'd1:    row_bits = glyph[29:25];
      3'd2:    row_bits = glyph[24:20];
      3'd3:    row_bits = glyph[19:15];
      3'd4:    row_bits = glyph[14:10];
      3'd5:    row_bits = glyph[9:5];
      3'd6:    row_bits = glyph[4:0];
      default: row_bits = '0;
    endcase
    pix_bit      = (col_reg < 3'd5) ? row_bits[3'd4 - col_reg] : 1'b0;
    display_next = in_box_reg & pix_bit & ~blank_gate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display <= 1'b0;
    end else begin
      display <= display_next;
    end
  end

`ifdef BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BC_W-1:0] blink_cnt_reg;
  logic            hidden_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      hidden_reg    <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_reg == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        hidden_reg    <= ~hidden_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign blank_gate = blink_req & hidden_reg;

  logic unused_bits;
  assign unused_bits = ^{col_full[9:3], cell_row[9:3]};
`else
  assign blank_gate = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{col_full[9:3], cell_row[9:3], blink_req, (BLINK_FRAMES > 0)};
`endif

endmodule
